// File: rtl/apb_pkg.sv
// Shared APB completer definitions: bus width defaults, FSM state encoding and address checking.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_WAIT_WIDTH = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} apb_slv_state_t;

  // Flags a byte address that is not word-aligned or falls past the last memory word.
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word memory behind the APB completer: synchronous write, combinational read, cleared on reset.
module apb_slave_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a word memory, programmable wait states and PSLVERR on bad addresses.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = 64
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      pselx,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [APB_WAIT_WIDTH-1:0] wait_cfg,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  apb_slv_state_t state_q, state_d;
  logic [APB_WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      write_q, write_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      we_c;
  logic [DATA_WIDTH-1:0]     rdata_c;

  // State and latched transfer attributes
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, wait countdown and write commit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    we_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pselx && !penable) begin
          idx_d   = paddr[IDX_W+1:2];
          write_d = pwrite;
          wdata_d = pwdata;
          err_d   = addr_err(64'(paddr), MEM_DEPTH);
          if (wait_cfg == '0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_cfg - APB_WAIT_WIDTH'(1);
          end
        end
      end
      S_WAIT: begin
        if (!pselx || !penable) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - APB_WAIT_WIDTH'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        we_c    = pselx && penable && write_q && !err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response is captured on entry to RESP so all three outputs come straight from flops
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= (state_d == S_RESP);
      pslverr <= (state_d == S_RESP) && err_d;
      prdata  <= ((state_d == S_RESP) && !err_d && !write_d) ? rdata_c : '0;
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_regfile (
    .pclk    (pclk),
    .presetn (presetn),
    .we      (we_c),
    .waddr   (idx_q),
    .wdata   (wdata_q),
    .raddr   (idx_d),
    .rdata   (rdata_c)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem with a queue of expected responses and a reference memory.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  wait_cfg;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic        is_read;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [64];
  int          total = 0;
  int          bad = 0;

  apb_slave_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (64)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .pselx    (pselx),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .wait_cfg (wait_cfg),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer; entered and left at posedge+1 so transfers chain with no idle cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] wc, input string tag);
    exp_t e;
    exp_t got;
    logic err;
    int   n;
    err       = (addr[1:0] != 2'b00) || (addr >= 32'h100);
    e.err     = err;
    e.waits   = int'(wc);
    e.is_read = !wr;
    e.rdata   = (!wr && !err) ? model_mem[addr[7:2]] : 32'h0;
    if (wr && !err) model_mem[addr[7:2]] = data;
    sb.push_back(e);

    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; wait_cfg = wc;
    @(posedge pclk); #1;
    penable  = 1'b1;
    wait_cfg = 4'($urandom_range(0, 15));
    n = 0;
    while (!pready && n < 40) begin
      @(posedge pclk); #1;
      n++;
    end
    got = sb.pop_front();
    if (!pready) begin
      chk({tag, "_timeout"}, 32'(pready), 32'h1);
    end else begin
      chk({tag, "_waits"}, 32'(n), 32'(got.waits));
      chk({tag, "_pslverr"}, 32'(pslverr), 32'(got.err));
      if (got.is_read) chk({tag, "_prdata"}, prdata, got.rdata);
    end
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    chk({tag, "_pready_one_cycle"}, 32'(pready), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    presetn = 1'b0; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; wait_cfg = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Reset while a read is in WAIT, then confirm memory was cleared
    xfer(1'b1, 32'h8, 32'hA5A5_5A5A, 4'd0, "pre_rst_wr");
    xfer(1'b0, 32'h8, 32'h0, 4'd2, "pre_rst_rd");
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8; wait_cfg = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    chk("midrst_pready", 32'(pready), 32'h0);
    chk("midrst_pslverr", 32'(pslverr), 32'h0);
    chk("midrst_prdata", prdata, 32'h0);
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    pselx = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 32'h8, 32'h0, 4'd0, "post_rst_rd");

    // Zero-wait write then read
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'd0, "zw_wr");
    xfer(1'b0, 32'h10, 32'h0, 4'd0, "zw_rd");

    // Wait-state counts
    xfer(1'b0, 32'h10, 32'h0, 4'd3, "w3_rd");
    xfer(1'b0, 32'h10, 32'h0, 4'd15, "w15_rd");

    // Error responses and suppressed writes
    xfer(1'b1, 32'hFC, 32'h0BAD_F00D, 4'd1, "last_wr");
    xfer(1'b1, 32'h102, 32'h1234_5678, 4'd0, "mis_wr");
    xfer(1'b1, 32'h12, 32'h1234_5678, 4'd2, "mis_alias_wr");
    xfer(1'b0, 32'h10, 32'h0, 4'd0, "mis_alias_chk");
    xfer(1'b0, 32'h100, 32'h0, 4'd0, "oor_rd");
    xfer(1'b0, 32'hFC, 32'h0, 4'd1, "last_rd");

    // Back-to-back alternating write/read with no idle cycles
    xfer(1'b1, 32'h0, 32'h1111_0000, 4'd0, "b2b_wr0");
    xfer(1'b0, 32'h0, 32'h0, 4'd0, "b2b_rd0");
    xfer(1'b1, 32'h4, 32'h2222_0004, 4'd0, "b2b_wr4");
    xfer(1'b0, 32'h4, 32'h0, 4'd0, "b2b_rd4");

    // Abort a write to 0x20 while in WAIT
    xfer(1'b1, 32'h20, 32'h1111_2222, 4'd0, "abort_pre_wr");
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h3333_4444; wait_cfg = 4'd3;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      chk("abort_pready", 32'(pready), 32'h0);
    end
    xfer(1'b0, 32'h20, 32'h0, 4'd0, "abort_rd");

    if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB slave (completer) that answers the transfers issued by the team's APB master. It contains a word-addressed memory of MEM_DEPTH entries and inserts a configurable number of wait states through PREADY. Misaligned or out-of-range accesses get PSLVERR. It sits on the peripheral side of the APB bus and is the default responder in master-side benches.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- MEM_DEPTH, 64, number of DATA_WIDTH words; power of two, at least 2
- pclk  in  1  bus clock; all logic on the rising edge
- presetn  in  1  reset, asynchronous, active-low
- pselx  in  1  slave select
- penable  in  1  access phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- wait_cfg  in  4  wait states for the next transfer; sampled in the setup cycle
- prdata  out  DATA_WIDTH  read data; valid when pready=1
- pready  out  1  transfer completes this cycle; registered
- pslverr  out  1  error response; valid when pready=1

## Operation
- FSM states:
  - IDLE: no transfer in progress.
  - WAIT: counting down wait states.
  - RESP: pready=1 for exactly one cycle.
- IDLE -> setup detected (pselx=1, penable=0). Latch paddr, pwrite, pwdata and wait_cfg, and compute the error flag.
  - If wait_cfg=0, go to RESP; otherwise go to WAIT with cnt=wait_cfg-1.
- WAIT:
  - If pselx=0 or penable=0, abort to IDLE. No write, no response.
  - Else if cnt=0, go to RESP; else decrement cnt.
- RESP -> IDLE, unconditionally.
  - A write commits at the RESP clock edge if pselx=1, penable=1 and err=0.
  - If the master drops pselx or penable during RESP, drop the write.
- Error (err=1) is raised in either case:
  - paddr[1:0]≠0 (misaligned).
  - paddr[ADDR_WIDTH-1:2] ≥ MEM_DEPTH (out of range).
  - On error, the write is suppressed, prdata=0 and pslverr=1 in RESP.
- Read: prdata is loaded from mem[index] when entering RESP.
- prdata and pslverr are forced to 0 outside RESP.
- Reset:
  - Clears every memory word to 0.
  - FSM goes to IDLE; pready=0, pslverr=0, prdata=0.
  - Reset mid-transfer abandons the transfer; the write is lost.

## Timing
- The setup cycle is cycle S. pready=1 in cycle S+1+wait_cfg, which is the first access cycle when wait_cfg=0.
- Back-to-back transfers: the master's next setup in cycle RESP+1 is detected from IDLE. There are no dead cycles beyond APB's own.
- Reading an address written by the previous transfer returns the new data.
- wait_cfg changes outside the setup cycle have no effect on the transfer in flight.
- Outputs are registered; no combinational path from the inputs to pready, pslverr or prdata.

## Structure
- Package apb_pkg holds:
  - the ADDR_WIDTH/DATA_WIDTH defaults;
  - typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} apb_slv_state_t;
  - the function that computes err from an address and MEM_DEPTH.
- Sub-module apb_slave_regfile holds the memory array: synchronous write, combinational read, reset clear. The top level holds the FSM, wait counter and response registers.

## Test plan
- Reset: assert presetn=0 mid-WAIT -> pready=0, pslverr=0, prdata=0 immediately; a read of 0x8 after reset returns 0.
- Zero-wait write then read:
  - write 0xDEADBEEF to 0x10 with wait_cfg=0 -> pready=1 in the first access cycle, pslverr=0;
  - read 0x10 -> prdata=0xDEADBEEF.
- Wait states: read with wait_cfg=3 -> exactly 3 access cycles with pready=0, then 1 cycle with pready=1. Then wait_cfg=15 -> 15 cycles with pready=0.
- Errors:
  - write to 0x102 (misaligned) -> pslverr=1, memory unchanged;
  - read 0x100 with MEM_DEPTH=64 -> pslverr=1, prdata=0;
  - read 0xFC -> pslverr=0.
- Back-to-back: 4 alternating write/read transfers to 0x0 and 0x4 with no idle cycles -> each completes; reads return the immediately preceding written values.
- Abort: drop pselx during WAIT of a write to 0x20 -> FSM in IDLE next cycle; read of 0x20 returns the old value.
